// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated FIFO writer.
// Latency: n/a (package). Backpressure: n/a.
// Holds the id-width calculation, the default memory-word layout and the round-robin search.
package fifo_arb_pkg;

    localparam int RR_MAX = 32;

    function automatic int calc_idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_DATASIZE = 8;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_IDW      = calc_idw(DEF_NREQ);

    typedef struct packed {
        logic [DEF_IDW-1:0]      src_id;
        logic [DEF_DATASIZE-1:0] payload;
    } mem_word_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then map back to a requester index.
    function automatic rr_pick_t rr_search(input logic [RR_MAX-1:0] req, input int n, input int ptr);
        logic [RR_MAX-1:0] rot;
        rr_pick_t          pick;
        int                j;
        rot  = '0;
        pick = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            if (i < n) begin
                j = ptr + i;
                if (j >= n) j = j - n;
                rot[i] = req[j];
            end
        end
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            if (rot[i]) begin
                j = ptr + i;
                if (j >= n) j = j - n;
                pick.found = 1'b1;
                pick.idx   = 5'(j);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifomem.sv
// Dual-port word store, synchronous write, fall-through or registered read.
// Latency: write visible on next cycle; read 0 cycles (fall-through) or 1 cycle (registered).
// Backpressure: writes are dropped while wfull is high; no read-side backpressure.
module fifomem #(
    parameter int    DATASIZE    = 8,
    parameter int    ADDRSIZE    = 4,
    parameter string FALLTHROUGH = "TRUE"
) (
    input  logic                wclk,
    input  logic                wclken,
    input  logic                wfull,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rclk,
    input  logic                rclken,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    logic [DATASIZE-1:0] mem [2**ADDRSIZE];

    always_ff @(posedge wclk) begin
        if (wclken && !wfull) mem[waddr] <= wdata;
    end

    generate
        if (FALLTHROUGH == "TRUE") begin : g_ft
            logic unused_rd;
            assign unused_rd = rclk ^ rclken;
            assign rdata     = mem[raddr];
        end else begin : g_reg
            logic [DATASIZE-1:0] rdata_q;
            always_ff @(posedge rclk) begin
                if (rclken) rdata_q <= mem[raddr];
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter, search begins at rr_ptr and wraps.
// Latency: combinational.
// Backpressure: enable low forces gnt to zero.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = calc_idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic [RR_MAX-1:0] req_ext;
    rr_pick_t          pick;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req;
        pick               = rr_search(req_ext, NREQ, int'(rr_ptr));
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = enable && pick.found && (pick.idx == 5'(i));
        end
    end

    assign gnt_idx = pick.idx[IDW-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shared FIFO fed by NREQ round-robin producers; each word carries its producer index.
// Latency: a word granted at edge N is at the head after edge N (fall-through read).
// Backpressure: grants withheld while full; pops on empty are ignored and flagged sticky in rd_err.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATASIZE    = 8,
    parameter int ADDRSIZE    = 4,
    parameter int NREQ        = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DATASIZE-1:0]   req_data,
    output logic [NREQ-1:0]            gnt,
    input  logic                       rd_en,
    output logic [DATASIZE-1:0]        rdata,
    output logic [$clog2(NREQ)-1:0]    rsrc,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [ADDRSIZE:0]          count,
    output logic                       rd_err
);

    localparam int IDW = calc_idw(NREQ);

    typedef struct packed {
        logic [IDW-1:0]      src_id;
        logic [DATASIZE-1:0] payload;
    } word_t;

    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    gnt_idx;
    logic              wr;
    logic              rd;
    word_t             wword;
    word_t             rword;

    assign empty       = (wptr == rptr);
    assign full        = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                         (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
    assign count       = wptr - rptr;
    assign almost_full = (count >= (ADDRSIZE+1)'(AFULL_LEVEL));

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .enable  (!full),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign wr            = |gnt;
    assign rd            = rd_en && !empty;
    assign wword.src_id  = gnt_idx;
    assign wword.payload = req_data[gnt_idx*DATASIZE +: DATASIZE];

    fifomem #(
        .DATASIZE    (DATASIZE + IDW),
        .ADDRSIZE    (ADDRSIZE),
        .FALLTHROUGH ("TRUE")
    ) u_mem (
        .wclk   (clk),
        .wclken (wr),
        .wfull  (full),
        .waddr  (wptr[ADDRSIZE-1:0]),
        .wdata  (wword),
        .rclk   (clk),
        .rclken (1'b1),
        .raddr  (rptr[ADDRSIZE-1:0]),
        .rdata  (rword)
    );

    assign rdata = rword.payload;
    assign rsrc  = rword.src_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            rr_ptr <= '0;
            rd_err <= 1'b0;
        end else begin
            if (wr) begin
                wptr   <= wptr + 1'b1;
                rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (rd) rptr <= rptr + 1'b1;
            if (rd_en && empty) rd_err <= 1'b1;
        end
    end

endmodule
